// File: rtl/xyolo_write_seq.sv
// xyolo_write_seq: internal-port sequencer for the YOLO write stage.
// On global_run it walks output pixels x accumulation taps and issues the
// vread port-B read stream, the pipeline-aligned xyolo load controls and
// the vwrite port-B write stream.
module xyolo_write_seq #(
  parameter int unsigned PIXEL_INT_ADDR_W = 10,
  parameter int unsigned VWRITE_ADDR_W    = 10,
  parameter int unsigned N_VECT           = 16,
  parameter int unsigned CNT_W            = 16,
  parameter int unsigned RD_LAT           = 2,
  parameter int unsigned WR_LAT           = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        global_run,
  output logic                        done,
  input  logic [CNT_W-1:0]            cfg_iter,
  input  logic [CNT_W-1:0]            cfg_per,
  input  logic [PIXEL_INT_ADDR_W-1:0] cfg_rd_start,
  input  logic [PIXEL_INT_ADDR_W-1:0] cfg_rd_shift,
  input  logic [PIXEL_INT_ADDR_W-1:0] cfg_rd_incr,
  input  logic [VWRITE_ADDR_W-1:0]    cfg_wr_start,
  input  logic [VWRITE_ADDR_W-1:0]    cfg_wr_incr,
  input  logic                        cfg_maxpool,
  input  logic [N_VECT-1:0]           cfg_lane_mask,
  output logic                        vread_enB,
  output logic [PIXEL_INT_ADDR_W-1:0] vread_addrB,
  output logic                        ld_acc,
  output logic                        ld_mp,
  output logic                        ld_res,
  output logic [N_VECT-1:0]           vwrite_enB,
  output logic [VWRITE_ADDR_W-1:0]    vwrite_addrB
);

  localparam int unsigned RES_DLY = RD_LAT + 1;
  localparam int unsigned WR_DLY  = RD_LAT + 1 + WR_LAT;
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(RD_LAT + WR_LAT);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FINISH} state_t;
  state_t state, state_nx;

  // Run configuration captured at start
  logic [CNT_W-1:0]            iter_last_q, per_last_q;
  logic [PIXEL_INT_ADDR_W-1:0] shift_q, incr_q;
  logic [VWRITE_ADDR_W-1:0]    wr_incr_q;
  logic                        mp_q;
  logic [N_VECT-1:0]           mask_q;

  // Loop counters and incremental address generators
  logic [CNT_W-1:0]            i_q, j_q, drain_q;
  logic [PIXEL_INT_ADDR_W-1:0] base_q, addr_q;
  logic [VWRITE_ADDR_W-1:0]    wa_q;
  logic                        done_q;

  // Delay lines aligning tap-level flags with the read/compute pipeline
  logic [RD_LAT-1:0]  acc_pipe;
  logic [RES_DLY-1:0] res_pipe, mp_pipe;
  logic [WR_DLY-1:0]  wr_pipe;

  logic start, run, last_tap, last_out;
  logic tap0_f, last_f, mp_f, wr_f, wr_fire;

  assign start    = (state == IDLE) && global_run;
  assign run      = (state == RUN);
  assign last_tap = (j_q == per_last_q);
  assign last_out = (i_q == iter_last_q);
  assign tap0_f   = run && (j_q == '0);
  assign last_f   = run && last_tap;
  assign mp_f     = last_f && mp_q && (i_q[1:0] == 2'd0);
  // Maxpool writes once per group of 4 outputs, plus a trailing partial group
  assign wr_f     = last_f && (!mp_q || (i_q[1:0] == 2'd3) || last_out);
  assign wr_fire  = wr_pipe[WR_DLY-1];

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (global_run) state_nx = (cfg_iter == '0) ? FINISH : RUN;
      RUN:     if (last_tap && last_out) state_nx = DRAIN;
      DRAIN:   if (drain_q == DRAIN_LAST) state_nx = FINISH;
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Config capture, loop counters and address generators
  always_ff @(posedge clk) begin
    if (rst) begin
      iter_last_q <= '0;
      per_last_q  <= '0;
      shift_q     <= '0;
      incr_q      <= '0;
      wr_incr_q   <= '0;
      mp_q        <= 1'b0;
      mask_q      <= '0;
      i_q         <= '0;
      j_q         <= '0;
      base_q      <= '0;
      addr_q      <= '0;
      wa_q        <= '0;
      drain_q     <= '0;
    end else begin
      if (start) begin
        iter_last_q <= cfg_iter - CNT_W'(1);
        per_last_q  <= (cfg_per == '0) ? '0 : cfg_per - CNT_W'(1);
        shift_q     <= cfg_rd_shift;
        incr_q      <= cfg_rd_incr;
        wr_incr_q   <= cfg_wr_incr;
        mp_q        <= cfg_maxpool;
        mask_q      <= cfg_lane_mask;
        i_q         <= '0;
        j_q         <= '0;
        base_q      <= cfg_rd_start;
        addr_q      <= cfg_rd_start;
        wa_q        <= cfg_wr_start;
      end else begin
        if (run) begin
          if (last_tap) begin
            j_q    <= '0;
            i_q    <= i_q + CNT_W'(1);
            base_q <= base_q + shift_q;
            addr_q <= base_q + shift_q;
          end else begin
            j_q    <= j_q + CNT_W'(1);
            addr_q <= addr_q + incr_q;
          end
        end
        if (wr_fire) wa_q <= wa_q + wr_incr_q;
      end
      drain_q <= (state == DRAIN) ? drain_q + CNT_W'(1) : '0;
    end
  end

  // Control delay lines, cleared on reset so no stray pulses survive
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_pipe <= '0;
      res_pipe <= '0;
      mp_pipe  <= '0;
      wr_pipe  <= '0;
    end else begin
      acc_pipe[0] <= tap0_f;
      res_pipe[0] <= last_f;
      mp_pipe[0]  <= mp_f;
      wr_pipe[0]  <= wr_f;
      for (int unsigned k = 1; k < RD_LAT; k++)  acc_pipe[k] <= acc_pipe[k-1];
      for (int unsigned k = 1; k < RES_DLY; k++) begin
        res_pipe[k] <= res_pipe[k-1];
        mp_pipe[k]  <= mp_pipe[k-1];
      end
      for (int unsigned k = 1; k < WR_DLY; k++)  wr_pipe[k] <= wr_pipe[k-1];
    end
  end

  // Done flag: cleared by an accepted start, set on entering FINISH
  always_ff @(posedge clk) begin
    if (rst)                     done_q <= 1'b0;
    else if (state_nx == FINISH) done_q <= 1'b1;
    else if (start)              done_q <= 1'b0;
  end

  // Output decode
  always_comb begin
    vread_enB    = run;
    vread_addrB  = run ? addr_q : '0;
    ld_acc       = acc_pipe[RD_LAT-1];
    ld_res       = res_pipe[RES_DLY-1];
    ld_mp        = mp_pipe[RES_DLY-1];
    vwrite_enB   = wr_fire ? mask_q : '0;
    vwrite_addrB = wr_fire ? wa_q : '0;
    done         = done_q;
  end

endmodule

// File: tb/tb_xyolo_write_seq.sv
// Directed bench for xyolo_write_seq: per-cycle trace checks against
// hand-computed tables. Cycle 0 is the global_run cycle.
module tb_xyolo_write_seq;

  logic        clk = 1'b0;
  logic        rst, global_run, done;
  logic [15:0] cfg_iter, cfg_per;
  logic [9:0]  cfg_rd_start, cfg_rd_shift, cfg_rd_incr;
  logic [9:0]  cfg_wr_start, cfg_wr_incr;
  logic        cfg_maxpool;
  logic [15:0] cfg_lane_mask;
  logic        vread_enB, ld_acc, ld_mp, ld_res;
  logic [9:0]  vread_addrB, vwrite_addrB;
  logic [15:0] vwrite_enB;

  int n_checks = 0;
  int n_pass   = 0;

  int a1[6] = '{10, 11, 12, 15, 16, 17};
  int a2[6] = '{100, 102, 104, 106, 108, 110};

  xyolo_write_seq #(
    .PIXEL_INT_ADDR_W(10), .VWRITE_ADDR_W(10), .N_VECT(16),
    .CNT_W(16), .RD_LAT(2), .WR_LAT(3)
  ) dut (
    .clk(clk), .rst(rst), .global_run(global_run), .done(done),
    .cfg_iter(cfg_iter), .cfg_per(cfg_per),
    .cfg_rd_start(cfg_rd_start), .cfg_rd_shift(cfg_rd_shift),
    .cfg_rd_incr(cfg_rd_incr), .cfg_wr_start(cfg_wr_start),
    .cfg_wr_incr(cfg_wr_incr), .cfg_maxpool(cfg_maxpool),
    .cfg_lane_mask(cfg_lane_mask), .vread_enB(vread_enB),
    .vread_addrB(vread_addrB), .ld_acc(ld_acc), .ld_mp(ld_mp),
    .ld_res(ld_res), .vwrite_enB(vwrite_enB), .vwrite_addrB(vwrite_addrB)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic set_cfg(input int n, input int p, input int rs, input int sh, input int inc,
                         input int ws, input int wi, input bit mp, input logic [15:0] mask);
    cfg_iter      = 16'(n);
    cfg_per       = 16'(p);
    cfg_rd_start  = 10'(rs);
    cfg_rd_shift  = 10'(sh);
    cfg_rd_incr   = 10'(inc);
    cfg_wr_start  = 10'(ws);
    cfg_wr_incr   = 10'(wi);
    cfg_maxpool   = mp;
    cfg_lane_mask = mask;
  endtask

  // Check all outputs at the negedge; entered and left at posedge+1
  task automatic check_outputs(input string pfx, input bit e_en, input int e_addr, input bit e_acc,
                               input bit e_res, input bit e_mp, input logic [15:0] e_wen,
                               input int e_waddr, input bit e_done);
    check({pfx, " vread_enB"},    32'(vread_enB),    32'(e_en));
    check({pfx, " vread_addrB"},  32'(vread_addrB),  32'(e_addr));
    check({pfx, " ld_acc"},       32'(ld_acc),       32'(e_acc));
    check({pfx, " ld_res"},       32'(ld_res),       32'(e_res));
    check({pfx, " ld_mp"},        32'(ld_mp),        32'(e_mp));
    check({pfx, " vwrite_enB"},   32'(vwrite_enB),   32'(e_wen));
    check({pfx, " vwrite_addrB"}, 32'(vwrite_addrB), 32'(e_waddr));
    check({pfx, " done"},         32'(done),         32'(e_done));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    global_run = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_outputs("reset", 1'b0, 0, 1'b0, 1'b0, 1'b0, 16'h0, 0, 1'b0);
    @(posedge clk); #1;
  endtask

  // scn 1: N=2 P=3 basic; 2: maxpool N=6 P=0; 3: N=0;
  // 4: scn 1 with reset in cycle 4; 5: wrap N=1 P=2 with extra global_run pulses
  task automatic run_scn(input int scn, input int ncyc, input int rst_at,
                         input int g_a, input int g_b, input bit cfg_change);
    bit e_en, e_acc, e_res, e_mp, e_done;
    int e_addr, e_waddr;
    logic [15:0] e_wen;
    for (int c = 0; c < ncyc; c++) begin
      global_run = (c == 0) || (c == g_a) || (c == g_b);
      rst        = (c == rst_at);
      if (cfg_change && c == 1) set_cfg(7, 9, 500, 33, 99, 300, 77, 1'b1, 16'h1234);
      e_en = 0; e_addr = 0; e_acc = 0; e_res = 0; e_mp = 0; e_wen = 0; e_waddr = 0; e_done = 0;
      case (scn)
        1, 4: if (!(scn == 4 && c > 4)) begin
          e_en    = (c >= 1 && c <= 6);
          e_addr  = e_en ? a1[c-1] : 0;
          e_acc   = (c == 3 || c == 6);
          e_res   = (c == 6 || c == 9);
          e_wen   = (c == 9 || c == 12) ? 16'h00FF : 16'h0;
          e_waddr = (c == 9) ? 4 : (c == 12) ? 5 : 0;
          e_done  = (c >= 13);
        end
        2: begin
          e_en    = (c >= 1 && c <= 6);
          e_addr  = e_en ? a2[c-1] : 0;
          e_acc   = (c >= 3 && c <= 8);
          e_res   = (c >= 4 && c <= 9);
          e_mp    = (c == 4 || c == 8);
          e_wen   = (c == 10 || c == 12) ? 16'hA5A5 : 16'h0;
          e_waddr = (c == 10) ? 20 : (c == 12) ? 23 : 0;
          e_done  = (c >= 13);
        end
        3: e_done = (c >= 1);
        5: begin
          e_en    = (c == 1 || c == 2);
          e_addr  = (c == 1) ? 1023 : 0;
          e_acc   = (c == 3);
          e_res   = (c == 5);
          e_wen   = (c == 8) ? 16'hFFFF : 16'h0;
          e_waddr = (c == 8) ? 1020 : 0;
          e_done  = (c >= 9);
        end
        default: ;
      endcase
      @(negedge clk);
      check_outputs($sformatf("s%0d c%0d", scn, c), e_en, e_addr, e_acc, e_res, e_mp,
                    e_wen, e_waddr, e_done);
      @(posedge clk); #1;
    end
    global_run = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    global_run = 1'b0;
    rst = 1'b1;
    set_cfg(2, 3, 10, 5, 1, 4, 1, 1'b0, 16'h00FF);
    @(posedge clk); #1;
    do_reset();

    set_cfg(2, 3, 10, 5, 1, 4, 1, 1'b0, 16'h00FF);
    run_scn(1, 16, -1, -1, -1, 1'b0);

    do_reset();
    set_cfg(6, 0, 100, 2, 7, 20, 3, 1'b1, 16'hA5A5);
    run_scn(2, 16, -1, -1, -1, 1'b0);

    do_reset();
    set_cfg(0, 3, 10, 5, 1, 4, 1, 1'b0, 16'hFFFF);
    run_scn(3, 5, -1, -1, -1, 1'b0);

    do_reset();
    set_cfg(2, 3, 10, 5, 1, 4, 1, 1'b0, 16'h00FF);
    run_scn(4, 16, 4, -1, -1, 1'b0);
    set_cfg(2, 3, 10, 5, 1, 4, 1, 1'b0, 16'h00FF);
    run_scn(1, 16, -1, -1, -1, 1'b1);

    do_reset();
    set_cfg(1, 2, 1023, 0, 1, 1020, 9, 1'b0, 16'hFFFF);
    run_scn(5, 12, -1, 1, 5, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
